// File: rtl/muldiv_unit_if.sv
// Handshake and result bus of the iterative multiply/divide unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, A, B,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle shift-add multiply
// and restoring divide on operand magnitudes, with signs applied in FIX.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state, state_next;

    logic [2*WIDTH-1:0] work;
    logic [WIDTH-1:0]   opnd;
    logic [CW-1:0]      iter_cnt;
    logic               is_div;
    logic               neg_main;
    logic               neg_rem;
    logic               dbz_pending;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               dbz_q;

    logic busy_c, load_op, step_op, commit_op, move_hi, move_lo;

    logic               signed_op;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH-1:0]   rem_signed;

    // Operand magnitudes at acceptance; unsigned ops never see a sign bit.
    always_comb begin
        signed_op = ~bus.op[0];
        sign_a    = signed_op & bus.A[WIDTH-1];
        sign_b    = signed_op & bus.B[WIDTH-1];
        mag_a     = sign_a ? (~bus.A + 1'b1) : bus.A;
        mag_b     = sign_b ? (~bus.B + 1'b1) : bus.B;
    end

    // One iteration of each algorithm plus the sign fix-up of the final value.
    // Divide keeps remainder in the upper half and the dividend/quotient in the lower half.
    always_comb begin
        mul_sum     = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
        mul_next    = {mul_sum, work[WIDTH-1:1]};
        div_trial   = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]} - {1'b0, opnd};
        div_next    = div_trial[WIDTH] ? {work[2*WIDTH-2:0], 1'b0}
                                       : {div_trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
        prod_signed = neg_main ? (~work + 1'b1) : work;
        quo_signed  = neg_main ? (~work[WIDTH-1:0] + 1'b1) : work[WIDTH-1:0];
        rem_signed  = neg_rem ? (~work[2*WIDTH-1:WIDTH] + 1'b1) : work[2*WIDTH-1:WIDTH];
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: mult/div ops (op[2]==0) leave IDLE; CALC runs WIDTH iterations.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start && !bus.op[2]) state_next = CALC;
            CALC: if (iter_cnt == CW'(WIDTH - 1)) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control strobes decoded from the state and the incoming request.
    always_comb begin
        busy_c    = 1'b0;
        load_op   = 1'b0;
        step_op   = 1'b0;
        commit_op = 1'b0;
        move_hi   = 1'b0;
        move_lo   = 1'b0;
        case (state)
            IDLE: begin
                load_op = bus.start && !bus.op[2];
                move_hi = bus.start && (bus.op == 3'b100);
                move_lo = bus.start && (bus.op == 3'b101);
            end
            CALC: begin
                busy_c  = 1'b1;
                step_op = 1'b1;
            end
            FIX: begin
                busy_c    = 1'b1;
                commit_op = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: latch operands, iterate, and commit HI/LO only on the FIX edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work        <= '0;
            opnd        <= '0;
            iter_cnt    <= '0;
            is_div      <= 1'b0;
            neg_main    <= 1'b0;
            neg_rem     <= 1'b0;
            dbz_pending <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            if (move_hi) hi_q <= bus.A;
            if (move_lo) lo_q <= bus.A;
            if (load_op) begin
                is_div      <= bus.op[1];
                neg_main    <= sign_a ^ sign_b;
                neg_rem     <= sign_a;
                dbz_pending <= bus.op[1] && (bus.B == '0);
                iter_cnt    <= '0;
                if (bus.op[1]) begin
                    opnd <= mag_b;
                    work <= {{WIDTH{1'b0}}, mag_a};
                end else begin
                    opnd <= mag_a;
                    work <= {{WIDTH{1'b0}}, mag_b};
                end
            end
            if (step_op) begin
                work     <= is_div ? div_next : mul_next;
                iter_cnt <= iter_cnt + CW'(1);
            end
            if (commit_op) begin
                done_q <= 1'b1;
                dbz_q  <= dbz_pending;
                if (!is_div) begin
                    hi_q <= prod_signed[2*WIDTH-1:WIDTH];
                    lo_q <= prod_signed[WIDTH-1:0];
                end else if (!dbz_pending) begin
                    hi_q <= rem_signed;
                    lo_q <= quo_signed;
                end
            end
        end
    end

    assign bus.busy        = busy_c;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    muldiv_unit_if #(.WIDTH(32)) dut_if ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present a request for exactly one rising edge; returns 1 ns after that edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dut_if.start = 1'b1;
        dut_if.op    = op;
        dut_if.A     = a;
        dut_if.B     = b;
        @(posedge clk);
        #1;
        dut_if.start = 1'b0;
    endtask

    // Counts sampled cycles (current one is 1) until done is seen; -1 on timeout.
    task automatic wait_done(output int cycles, output logic dbz_seen);
        cycles = 1;
        while (dut_if.done !== 1'b1 && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (dut_if.done !== 1'b1) cycles = -1;
        dbz_seen = dut_if.div_by_zero;
    endtask

    task automatic test_reset;
        reset        = 1'b1;
        dut_if.start = 1'b0;
        dut_if.op    = 3'b110;
        dut_if.A     = '0;
        dut_if.B     = '0;
        #2;
        checks++; if (dut_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", dut_if.busy); end
        checks++; if (dut_if.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", dut_if.done); end
        checks++; if (dut_if.div_by_zero !== 1'b0) begin failures++; $display("[TB] FAIL reset_dbz: got %b expected 0", dut_if.div_by_zero); end
        checks++; if (dut_if.hi !== 32'h0) begin failures++; $display("[TB] FAIL reset_hi: got %h expected 00000000", dut_if.hi); end
        checks++; if (dut_if.lo !== 32'h0) begin failures++; $display("[TB] FAIL reset_lo: got %h expected 00000000", dut_if.lo); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mult;
        int   cyc;
        logic dbz;
        applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'h00000007);
        checks++; if (dut_if.busy !== 1'b1) begin failures++; $display("[TB] FAIL mult_busy: got %b expected 1", dut_if.busy); end
        checks++; if (dut_if.hi !== 32'h0) begin failures++; $display("[TB] FAIL mult_hi_hidden: got %h expected 00000000", dut_if.hi); end
        wait_done(cyc, dbz);
        checks++; if (cyc !== 34) begin failures++; $display("[TB] FAIL mult_latency: got %0d expected 34", cyc); end
        checks++; if (dut_if.hi !== 32'hFFFFFFFF) begin failures++; $display("[TB] FAIL mult_hi: got %h expected FFFFFFFF", dut_if.hi); end
        checks++; if (dut_if.lo !== 32'hFFFFFFEB) begin failures++; $display("[TB] FAIL mult_lo: got %h expected FFFFFFEB", dut_if.lo); end
        checks++; if (dut_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL mult_busy_at_done: got %b expected 0", dut_if.busy); end
        @(posedge clk);
        #1;
        checks++; if (dut_if.done !== 1'b0) begin failures++; $display("[TB] FAIL mult_done_pulse: got %b expected 0", dut_if.done); end

        applyStimulus(OP_MULTU, 32'hFFFFFFFD, 32'h00000007);
        wait_done(cyc, dbz);
        checks++; if (cyc !== 34) begin failures++; $display("[TB] FAIL multu_latency: got %0d expected 34", cyc); end
        checks++; if (dut_if.hi !== 32'h00000006) begin failures++; $display("[TB] FAIL multu_hi: got %h expected 00000006", dut_if.hi); end
        checks++; if (dut_if.lo !== 32'hFFFFFFEB) begin failures++; $display("[TB] FAIL multu_lo: got %h expected FFFFFFEB", dut_if.lo); end
    endtask

    task automatic test_div;
        int   cyc;
        logic dbz;
        applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'h00000002);
        wait_done(cyc, dbz);
        checks++; if (cyc !== 34) begin failures++; $display("[TB] FAIL div_latency: got %0d expected 34", cyc); end
        checks++; if (dut_if.lo !== 32'hFFFFFFFD) begin failures++; $display("[TB] FAIL div_lo: got %h expected FFFFFFFD", dut_if.lo); end
        checks++; if (dut_if.hi !== 32'hFFFFFFFF) begin failures++; $display("[TB] FAIL div_hi: got %h expected FFFFFFFF", dut_if.hi); end
        checks++; if (dbz !== 1'b0) begin failures++; $display("[TB] FAIL div_dbz: got %b expected 0", dbz); end

        applyStimulus(OP_DIVU, 32'h00000007, 32'h00000002);
        wait_done(cyc, dbz);
        checks++; if (dut_if.lo !== 32'h00000003) begin failures++; $display("[TB] FAIL divu_lo: got %h expected 00000003", dut_if.lo); end
        checks++; if (dut_if.hi !== 32'h00000001) begin failures++; $display("[TB] FAIL divu_hi: got %h expected 00000001", dut_if.hi); end

        applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(cyc, dbz);
        checks++; if (dut_if.lo !== 32'h80000000) begin failures++; $display("[TB] FAIL divmin_lo: got %h expected 80000000", dut_if.lo); end
        checks++; if (dut_if.hi !== 32'h00000000) begin failures++; $display("[TB] FAIL divmin_hi: got %h expected 00000000", dut_if.hi); end
        checks++; if (dbz !== 1'b0) begin failures++; $display("[TB] FAIL divmin_dbz: got %b expected 0", dbz); end
    endtask

    task automatic test_div_by_zero;
        int   cyc;
        logic dbz;
        applyStimulus(OP_MTHI, 32'hAAAA5555, 32'h0);
        applyStimulus(OP_MTLO, 32'h12345678, 32'h0);
        checks++; if (dut_if.hi !== 32'hAAAA5555) begin failures++; $display("[TB] FAIL preload_hi: got %h expected AAAA5555", dut_if.hi); end
        checks++; if (dut_if.lo !== 32'h12345678) begin failures++; $display("[TB] FAIL preload_lo: got %h expected 12345678", dut_if.lo); end
        applyStimulus(OP_DIVU, 32'h00000005, 32'h00000000);
        wait_done(cyc, dbz);
        checks++; if (cyc !== 34) begin failures++; $display("[TB] FAIL dbz_latency: got %0d expected 34", cyc); end
        checks++; if (dbz !== 1'b1) begin failures++; $display("[TB] FAIL dbz_flag: got %b expected 1", dbz); end
        checks++; if (dut_if.hi !== 32'hAAAA5555) begin failures++; $display("[TB] FAIL dbz_hi: got %h expected AAAA5555", dut_if.hi); end
        checks++; if (dut_if.lo !== 32'h12345678) begin failures++; $display("[TB] FAIL dbz_lo: got %h expected 12345678", dut_if.lo); end
        @(posedge clk);
        #1;
        checks++; if (dut_if.div_by_zero !== 1'b0) begin failures++; $display("[TB] FAIL dbz_pulse: got %b expected 0", dut_if.div_by_zero); end
    endtask

    task automatic test_move;
        applyStimulus(OP_MTHI, 32'hDEADBEEF, 32'h0);
        checks++; if (dut_if.hi !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL mthi_hi: got %h expected DEADBEEF", dut_if.hi); end
        checks++; if (dut_if.lo !== 32'h12345678) begin failures++; $display("[TB] FAIL mthi_lo: got %h expected 12345678", dut_if.lo); end
        checks++; if (dut_if.done !== 1'b0) begin failures++; $display("[TB] FAIL mthi_done: got %b expected 0", dut_if.done); end
        checks++; if (dut_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL mthi_busy: got %b expected 0", dut_if.busy); end
        applyStimulus(3'b111, 32'h01010101, 32'h02020202);
        checks++; if (dut_if.hi !== 32'hDEADBEEF || dut_if.lo !== 32'h12345678 || dut_if.busy !== 1'b0)
            begin failures++; $display("[TB] FAIL nop_effect: got hi=%h lo=%h busy=%b expected DEADBEEF 12345678 0", dut_if.hi, dut_if.lo, dut_if.busy); end
    endtask

    task automatic test_busy_ignore;
        int   cyc;
        logic dbz;
        applyStimulus(OP_MULT, 32'h00000005, 32'h00000006);
        repeat (2) begin @(posedge clk); #1; end
        dut_if.start = 1'b1;
        dut_if.op    = OP_MTHI;
        dut_if.A     = 32'h0BADF00D;
        dut_if.B     = 32'h00000001;
        @(posedge clk);
        #1;
        dut_if.start = 1'b0;
        dut_if.A     = 32'h00000011;
        dut_if.B     = 32'h00000022;
        checks++; if (dut_if.hi !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL ignore_hi: got %h expected DEADBEEF", dut_if.hi); end
        checks++; if (dut_if.busy !== 1'b1) begin failures++; $display("[TB] FAIL ignore_busy: got %b expected 1", dut_if.busy); end
        wait_done(cyc, dbz);
        checks++; if (cyc !== 31) begin failures++; $display("[TB] FAIL ignore_latency: got %0d expected 31", cyc); end
        checks++; if (dut_if.hi !== 32'h00000000) begin failures++; $display("[TB] FAIL ignore_res_hi: got %h expected 00000000", dut_if.hi); end
        checks++; if (dut_if.lo !== 32'h0000001E) begin failures++; $display("[TB] FAIL ignore_res_lo: got %h expected 0000001E", dut_if.lo); end
    endtask

    task automatic test_back_to_back;
        int   cyc;
        logic dbz;
        applyStimulus(OP_MULTU, 32'h00000003, 32'h00000004);
        wait_done(cyc, dbz);
        checks++; if (dut_if.lo !== 32'h0000000C) begin failures++; $display("[TB] FAIL b2b_first_lo: got %h expected 0000000C", dut_if.lo); end
        dut_if.start = 1'b1;
        dut_if.op    = OP_DIV;
        dut_if.A     = 32'hFFFFFF9C;
        dut_if.B     = 32'h00000007;
        @(posedge clk);
        #1;
        dut_if.start = 1'b0;
        checks++; if (dut_if.busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_busy: got %b expected 1", dut_if.busy); end
        wait_done(cyc, dbz);
        checks++; if (cyc !== 34) begin failures++; $display("[TB] FAIL b2b_latency: got %0d expected 34", cyc); end
        checks++; if (dut_if.lo !== 32'hFFFFFFF2) begin failures++; $display("[TB] FAIL b2b_lo: got %h expected FFFFFFF2", dut_if.lo); end
        checks++; if (dut_if.hi !== 32'hFFFFFFFE) begin failures++; $display("[TB] FAIL b2b_hi: got %h expected FFFFFFFE", dut_if.hi); end
    endtask

    task automatic test_reset_mid;
        int   cyc;
        logic dbz;
        logic done_seen;
        applyStimulus(OP_MULT, 32'h00000003, 32'h00000003);
        repeat (9) begin @(posedge clk); #1; end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (dut_if.busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy: got %b expected 0", dut_if.busy); end
        checks++; if (dut_if.hi !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_hi: got %h expected 00000000", dut_if.hi); end
        checks++; if (dut_if.lo !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_lo: got %h expected 00000000", dut_if.lo); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (dut_if.done === 1'b1 || dut_if.busy === 1'b1) done_seen = 1'b1;
        end
        checks++; if (done_seen !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_no_done: got %b expected 0", done_seen); end
        applyStimulus(OP_DIVU, 32'h00000009, 32'h00000004);
        wait_done(cyc, dbz);
        checks++; if (cyc !== 34) begin failures++; $display("[TB] FAIL postrst_latency: got %0d expected 34", cyc); end
        checks++; if (dut_if.lo !== 32'h00000002 || dut_if.hi !== 32'h00000001)
            begin failures++; $display("[TB] FAIL postrst_result: got hi=%h lo=%h expected 00000001 00000002", dut_if.hi, dut_if.lo); end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_mult();
        test_div();
        test_div_by_zero();
        test_move();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
